// File: rtl/simon_pkg.sv
// Shared types and width helpers for the Simon Says input checker.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    RELEASE,
    DONE,
    FAIL
  } vs_state_t;

  typedef enum logic [1:0] {
    FC_WRONG,
    FC_MULTI,
    FC_TIMEOUT,
    FC_EMPTY
  } fail_code_t;

  // Symbol width: button index plus an MSB that marks an empty pattern entry.
  function automatic int unsigned sym_width(input int unsigned num_buttons);
    return $clog2(num_buttons) + 1;
  endfunction

  // Round-length width: must hold the value MAX_ROUNDS itself.
  function automatic int unsigned round_width(input int unsigned max_rounds);
    return $clog2(max_rounds + 1);
  endfunction

endpackage

// File: rtl/verify_sequence_if.sv
// Connection between the game FSM / button synchroniser and the sequence checker.
interface verify_sequence_if #(
  parameter int unsigned NUM_BUTTONS = 4,
  parameter int unsigned MAX_ROUNDS  = 32
);
  import simon_pkg::*;

  localparam int unsigned SYM_W = sym_width(NUM_BUTTONS);
  localparam int unsigned RW    = round_width(MAX_ROUNDS);

  logic                        start;
  logic [RW-1:0]               round_len;
  logic [MAX_ROUNDS*SYM_W-1:0] segment;
  logic [NUM_BUTTONS-1:0]      player_input;
  logic                        busy;
  logic [RW-1:0]               check_idx;
  logic                        step_ok;
  logic                        done;
  logic                        fail;
  logic [1:0]                  fail_code;

  // Game side: issues rounds and supplies the pattern and button levels.
  modport master (
    output start, round_len, segment, player_input,
    input  busy, check_idx, step_ok, done, fail, fail_code
  );

  // Checker side.
  modport slave (
    input  start, round_len, segment, player_input,
    output busy, check_idx, step_ok, done, fail, fail_code
  );

endinterface

// File: rtl/button_encoder.sv
// Converts button levels to a button index; valid only when exactly one button is down.
module button_encoder #(
  parameter int unsigned NUM_BUTTONS = 4
) (
  input  logic [NUM_BUTTONS-1:0]         buttons_i,
  output logic                           valid_o,
  output logic [$clog2(NUM_BUTTONS)-1:0] index_o
);

  localparam int unsigned IDX_W = $clog2(NUM_BUTTONS);

  // One-hot detect and index of the (highest) set bit.
  always_comb begin
    valid_o = ($countones(buttons_i) == 1);
    index_o = '0;
    for (int unsigned k = 0; k < NUM_BUTTONS; k++) begin
      if (buttons_i[k]) index_o = IDX_W'(k);
    end
  end

endmodule

// File: rtl/verify_sequence.sv
// Steps through a Simon Says pattern one press at a time, reporting each accepted press,
// round completion, or the reason the round failed.
module verify_sequence
  import simon_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 4,
  parameter int unsigned MAX_ROUNDS     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input logic              clk,
  input logic              reset,
  verify_sequence_if.slave bus
);

  localparam int unsigned SYM_W = sym_width(NUM_BUTTONS);
  localparam int unsigned RW    = round_width(MAX_ROUNDS);
  localparam int unsigned IDX_W = SYM_W - 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] LEN_MAX    = RW'(MAX_ROUNDS);

  vs_state_t              state_q;
  logic [RW-1:0]          len_q;
  logic [RW-1:0]          check_idx_q;
  logic [TW-1:0]          timer_q;
  logic [NUM_BUTTONS-1:0] prev_input_q;
  logic                   step_ok_q;
  logic                   done_q;
  logic                   fail_q;
  fail_code_t             fail_code_q;

  logic [SYM_W-1:0] cur_entry;
  logic [SYM_W-1:0] press_sym;
  logic [IDX_W-1:0] press_idx;
  logic             press_valid;
  logic             press;

  button_encoder #(
    .NUM_BUTTONS(NUM_BUTTONS)
  ) u_encoder (
    .buttons_i(bus.player_input),
    .valid_o  (press_valid),
    .index_o  (press_idx)
  );

  assign press     = (bus.player_input != '0) && (prev_input_q == '0);
  assign press_sym = {1'b0, press_idx};

  // Live pattern lookup at the current index; segment is held stable while busy.
  always_comb begin
    cur_entry = '0;
    for (int unsigned i = 0; i < MAX_ROUNDS; i++) begin
      if (check_idx_q == RW'(i)) cur_entry = bus.segment[i*SYM_W +: SYM_W];
    end
  end

  // Round FSM with index counter, saturating idle timer and registered pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      check_idx_q  <= '0;
      timer_q      <= '0;
      prev_input_q <= '0;
      step_ok_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_code_q  <= FC_WRONG;
    end else begin
      prev_input_q <= bus.player_input;
      step_ok_q    <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      // start wins in every state: an in-flight round is dropped without a pulse.
      if (bus.start) begin
        len_q       <= bus.round_len;
        check_idx_q <= '0;
        timer_q     <= '0;
        fail_code_q <= FC_WRONG;
        if (bus.round_len == '0 || bus.round_len > LEN_MAX) begin
          state_q     <= FAIL;
          fail_q      <= 1'b1;
          fail_code_q <= FC_EMPTY;
        end else begin
          state_q <= ARM;
        end
      end else begin
        unique case (state_q)
          IDLE: ;
          ARM: begin
            // A button still held from before start must be released first.
            if (bus.player_input == '0) begin
              timer_q <= '0;
              state_q <= WAIT;
            end
          end
          WAIT: begin
            if (timer_q != TIMER_LAST) timer_q <= timer_q + TW'(1);
            if (cur_entry[SYM_W-1]) begin
              state_q     <= FAIL;
              fail_q      <= 1'b1;
              fail_code_q <= FC_EMPTY;
            end else if (press) begin
              if (!press_valid) begin
                state_q     <= FAIL;
                fail_q      <= 1'b1;
                fail_code_q <= FC_MULTI;
              end else if (press_sym != cur_entry) begin
                state_q     <= FAIL;
                fail_q      <= 1'b1;
                fail_code_q <= FC_WRONG;
              end else begin
                step_ok_q <= 1'b1;
                state_q   <= RELEASE;
              end
            end else if (timer_q == TIMER_LAST) begin
              state_q     <= FAIL;
              fail_q      <= 1'b1;
              fail_code_q <= FC_TIMEOUT;
            end
          end
          RELEASE: begin
            if (bus.player_input == '0) begin
              if (check_idx_q == len_q - RW'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                check_idx_q <= check_idx_q + RW'(1);
                timer_q     <= '0;
                state_q     <= WAIT;
              end
            end
          end
          DONE:    state_q <= IDLE;
          FAIL:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.check_idx = check_idx_q;
  assign bus.step_ok   = step_ok_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = fail_code_q;

endmodule
